// File: rtl/tmds_align_ctrl.sv
// tmds_align_ctrl: word-alignment controller for one TMDS channel.
// Slips the deserializer until control-token runs appear, then tracks lock.
module tmds_align_ctrl #(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_CYCLES = 4096,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOSS_TIMEOUT  = 4096
) (
  input  logic       clk_1x_in,
  input  logic       rst_n_in,
  input  logic [9:0] deser_data,
  output logic       bitslip_out,
  output logic       aligned_out,
  output logic [3:0] slip_count_out,
  output logic       lock_lost_out
);
  localparam int RW = $clog2(TOKEN_RUN + 1);
  localparam int WW = $clog2(SEARCH_CYCLES);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(LOSS_TIMEOUT);

  localparam logic [RW-1:0] RUN_MAX = RW'(TOKEN_RUN);
  localparam logic [RW-1:0] RUN_PRE = RW'(TOKEN_RUN - 1);
  localparam logic [WW-1:0] WIN_END = WW'(SEARCH_CYCLES - 1);
  localparam logic [SW-1:0] ST_END  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_END  = TW'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SLIP,
    S_SETTLE,
    S_LOCKED
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [RW-1:0] run_cnt;
  logic [WW-1:0] win_cnt;
  logic [SW-1:0] st_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    slip_cnt;

  logic tok;
  logic blind;
  logic run_max;
  logic run_hit;
  logic win_end;
  logic st_end;
  logic to_end;

  assign tok = deser_data inside {
    10'b1101010100, 10'b0010101011,
    10'b0101010100, 10'b1010101011
  };

  assign blind   = (state == S_SLIP) || (state == S_SETTLE);
  assign run_max = (run_cnt == RUN_MAX);
  // completion edge of a token run: run_cnt is about to reach TOKEN_RUN
  assign run_hit = !blind && tok && (run_cnt == RUN_PRE);
  assign win_end = (win_cnt == WIN_END);
  assign st_end  = (st_cnt == ST_END);
  assign to_end  = (to_cnt == TO_END);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_SEARCH: begin
        if (run_max) state_nx = S_LOCKED;
        else if (win_end) state_nx = S_SLIP;
      end
      S_SLIP: state_nx = S_SETTLE;
      S_SETTLE: begin
        if (st_end) state_nx = S_SEARCH;
      end
      S_LOCKED: begin
        if (!run_hit && to_end) state_nx = S_SEARCH;
      end
      default: state_nx = S_SEARCH;
    endcase
  end

  always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= S_SEARCH;
      run_cnt        <= '0;
      win_cnt        <= '0;
      st_cnt         <= '0;
      to_cnt         <= '0;
      slip_cnt       <= '0;
      bitslip_out    <= 1'b0;
      aligned_out    <= 1'b0;
      slip_count_out <= '0;
      lock_lost_out  <= 1'b0;
    end else begin
      state <= state_nx;

      if (blind || !tok) run_cnt <= '0;
      else if (!run_max) run_cnt <= run_cnt + 1'b1;

      if (state == S_SEARCH && state_nx == S_SEARCH)
        win_cnt <= win_cnt + 1'b1;
      else
        win_cnt <= '0;

      if (state == S_SETTLE && !st_end) st_cnt <= st_cnt + 1'b1;
      else st_cnt <= '0;

      // to_cnt measures cycles since the last completed run
      if (run_hit) to_cnt <= '0;
      else if (!to_end) to_cnt <= to_cnt + 1'b1;

      if (state_nx == S_SLIP) begin
        slip_cnt       <= (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
        slip_count_out <= (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
      end

      bitslip_out   <= (state_nx == S_SLIP);
      aligned_out   <= (state_nx == S_LOCKED);
      lock_lost_out <= (state == S_LOCKED) && (state_nx == S_SEARCH);
    end
  end
endmodule

// File: tb/tb_tmds_align_ctrl.sv
// tb_tmds_align_ctrl: directed bench with a word-rotator channel model
// and a cycle-level behavioural reference for tmds_align_ctrl.
module tb_tmds_align_ctrl;
  localparam int TR = 8;
  localparam int SC = 64;
  localparam int ST = 4;
  localparam int LT = 128;

  logic       clk_1x_in = 1'b0;
  logic       rst_n_in = 1'b1;
  logic [9:0] deser_data = '0;
  logic       bitslip_out;
  logic       aligned_out;
  logic [3:0] slip_count_out;
  logic       lock_lost_out;

  tmds_align_ctrl #(
    .TOKEN_RUN(TR),
    .SEARCH_CYCLES(SC),
    .SETTLE_CYCLES(ST),
    .LOSS_TIMEOUT(LT)
  ) dut (
    .clk_1x_in(clk_1x_in),
    .rst_n_in(rst_n_in),
    .deser_data(deser_data),
    .bitslip_out(bitslip_out),
    .aligned_out(aligned_out),
    .slip_count_out(slip_count_out),
    .lock_lost_out(lock_lost_out)
  );

  always #5 clk_1x_in = ~clk_1x_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int offset = 0;

  logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  function automatic bit is_tok(input logic [9:0] w);
    return w inside {10'h354, 10'h0AB, 10'h154, 10'h2AB};
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w, input int n);
    logic [9:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  function automatic logic [9:0] rnd_data();
    logic [9:0] w;
    do w = 10'($urandom); while (is_tok(w));
    return w;
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  always @(posedge clk_1x_in or negedge rst_n_in)
    if (!rst_n_in) cyc = 0;
    else cyc++;

  // reference: unlocked life is a 69-cycle phase wheel t (search, slip, settle)
  bit m_lk;
  int m_t, m_run, m_since, m_sc;
  bit e_bs, e_al, e_ll;

  task automatic model_step(input logic [9:0] w);
    bit blind, tok, done;
    int run0, since0;
    blind = !m_lk && (m_t >= SC);
    tok = is_tok(w);
    run0 = m_run;
    since0 = m_since;
    done = !blind && tok && (run0 == TR - 1);
    m_run = blind ? 0 : (tok ? ((run0 < TR) ? run0 + 1 : TR) : 0);
    m_since = done ? 0 : ((since0 < LT - 1) ? since0 + 1 : since0);
    e_ll = 0;
    if (m_lk) begin
      if (!done && since0 == LT - 1) begin
        m_lk = 0;
        m_t = 0;
        e_ll = 1;
      end
    end else if (m_t < SC) begin
      if (run0 == TR) m_lk = 1;
      else begin
        if (m_t == SC - 1) m_sc = (m_sc + 1) % 10;
        m_t++;
      end
    end else begin
      m_t = (m_t == SC + ST) ? 0 : m_t + 1;
    end
    e_bs = !m_lk && (m_t == SC);
    e_al = m_lk;
  endtask

  always @(posedge clk_1x_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_lk = 0; m_t = 0; m_run = 0; m_since = 0; m_sc = 0;
      e_bs = 0; e_al = 0; e_ll = 0;
    end else begin
      model_step(deser_data);
    end
  end

  always @(negedge clk_1x_in) begin
    checks++;
    if ({bitslip_out, aligned_out, lock_lost_out, slip_count_out}
        !== {e_bs, e_al, e_ll, 4'(m_sc)}) begin
      errors++;
      $display("FAIL cyc%0d bs/al/ll/sc got %b%b%b/%0d want %b%b%b/%0d",
               cyc, bitslip_out, aligned_out, lock_lost_out, slip_count_out,
               e_bs, e_al, e_ll, m_sc);
    end
  end

  int bs_q[$], bs_sc_q[$], rise_q[$], fall_q[$], ll_q[$];
  bit al_d = 0;

  always @(negedge clk_1x_in) begin
    if (rst_n_in) begin
      if (bitslip_out) begin
        bs_q.push_back(cyc);
        bs_sc_q.push_back(int'(slip_count_out));
      end
      if (aligned_out && !al_d) rise_q.push_back(cyc);
      if (!aligned_out && al_d) fall_q.push_back(cyc);
      if (lock_lost_out) ll_q.push_back(cyc);
    end
    al_d = aligned_out;
  end

  task automatic clr();
    bs_q.delete(); bs_sc_q.delete(); rise_q.delete();
    fall_q.delete(); ll_q.delete();
  endtask

  // channel: one word per cycle; a seen bitslip pulls the rotation back by one
  task automatic put(input logic [9:0] w);
    if (bitslip_out) offset = (offset + 9) % 10;
    deser_data = rot(w, offset);
    @(negedge clk_1x_in);
  endtask

  task automatic do_reset();
    #1 rst_n_in = 1'b0;
    deser_data = '0;
    repeat (2) @(negedge clk_1x_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    // test 1: aligned channel locks 9 edges after reset
    offset = 0;
    do_reset();
    clr();
    repeat (12) put(10'h354);
    #1;
    chk("t1_rise_edge", at(rise_q, 0), 9);
    chk("t1_no_slip", bs_q.size(), 0);
    chk("t1_slip_count", int'(slip_count_out), 0);
    chk("t1_aligned", int'(aligned_out), 1);

    // test 4: tokens stop; last run completed at edge 8
    clr();
    repeat (210) put(rnd_data());
    #1;
    chk("t4_ll_pulses", ll_q.size(), 1);
    chk("t4_ll_edge", at(ll_q, 0), 136);
    chk("t4_fall_edge", at(fall_q, 0), 136);
    chk("t4_slip_edge", at(bs_q, 0), 200);

    // test 2: offset 3, line of 20 tokens + 100 data words
    offset = 3;
    do_reset();
    clr();
    repeat (330) begin
      if (((cyc + 1 + 30) % 120) < 20) put(toks[cyc % 4]);
      else put(rnd_data());
    end
    #1;
    chk("t2_slips", bs_q.size(), 3);
    chk("t2_slip0", at(bs_q, 0), 64);
    chk("t2_gap1", at(bs_q, 1) - at(bs_q, 0), 69);
    chk("t2_gap2", at(bs_q, 2) - at(bs_q, 1), 69);
    chk("t2_sc_at_slip3", at(bs_sc_q, 2), 3);
    chk("t2_slip_count", int'(slip_count_out), 3);
    chk("t2_rise_edge", at(rise_q, 0), 218);
    chk("t2_aligned", int'(aligned_out), 1);

    // test 3: runs of 7 tokens never lock
    offset = 0;
    do_reset();
    clr();
    for (int i = 0; i < 70; i++) begin
      if ((i % 8) < 7) put(toks[i % 4]);
      else put(rnd_data());
    end
    #1;
    chk("t3_no_lock", rise_q.size(), 0);
    chk("t3_slip_edge", at(bs_q, 0), 64);

    // test 5: pure data, slip wheel wraps
    offset = 0;
    do_reset();
    clr();
    repeat (800) put(rnd_data());
    #1;
    chk("t5_slips", bs_q.size(), 11);
    chk("t5_slip0", at(bs_q, 0), 64);
    for (int i = 1; i < 11; i++)
      chk($sformatf("t5_gap%0d", i), at(bs_q, i) - at(bs_q, i - 1), 69);
    for (int i = 0; i < 11; i++)
      chk($sformatf("t5_sc%0d", i), at(bs_sc_q, i), (i + 1) % 10);
    chk("t5_no_ll", ll_q.size(), 0);

    // test 6a: reset in the middle of SETTLE
    offset = 0;
    do_reset();
    clr();
    repeat (66) put(rnd_data());
    chk("t6_pre_sc", int'(slip_count_out), 1);
    @(posedge clk_1x_in);
    #2 rst_n_in = 1'b0;
    #1;
    chk("t6a_bs", int'(bitslip_out), 0);
    chk("t6a_al", int'(aligned_out), 0);
    chk("t6a_ll", int'(lock_lost_out), 0);
    chk("t6a_sc", int'(slip_count_out), 0);
    @(negedge clk_1x_in);
    rst_n_in = 1'b1;
    clr();
    repeat (66) put(rnd_data());
    #1;
    chk("t6a_restart_slip", at(bs_q, 0), 64);
    chk("t6a_restart_sc", at(bs_sc_q, 0), 1);

    // test 6b: reset while LOCKED
    offset = 0;
    do_reset();
    clr();
    repeat (20) put(toks[cyc % 4]);
    chk("t6b_locked", int'(aligned_out), 1);
    @(posedge clk_1x_in);
    #3 rst_n_in = 1'b0;
    #1;
    chk("t6b_al", int'(aligned_out), 0);
    chk("t6b_sc", int'(slip_count_out), 0);
    chk("t6b_bs", int'(bitslip_out), 0);
    @(negedge clk_1x_in);
    rst_n_in = 1'b1;
    clr();
    repeat (5) put(rnd_data());
    #1;
    chk("t6b_after_al", int'(aligned_out), 0);
    chk("t6b_after_sc", int'(slip_count_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
